// File: rtl/tomasula_types.sv
// Shared Tomasulo back-end types: operation classes plus reservation-station
// entry and CDB lane layouts sized by the package tag/data widths.
package tomasula_types;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_REG    = 3'd0,
        OP_IMM    = 3'd1,
        OP_LUI    = 3'd2,
        OP_AUIPC  = 3'd3,
        OP_BRANCH = 3'd4,
        OP_JAL    = 3'd5,
        OP_JALR   = 3'd6,
        OP_MEM    = 3'd7
    } op_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              valid;
    } rs_src_t;

    typedef struct packed {
        logic             busy;
        op_t              op;
        logic [2:0]       funct3;
        logic             funct7;
        logic [TAG_W-1:0] rd_tag;
        rs_src_t          src1;
        rs_src_t          src2;
    } rs_entry_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_lane_t;

endpackage

// File: rtl/res_station_bank_age.sv
// Older-than bit matrix: olderQ[i][j] set means entry i was allocated before
// entry j. Picks the single oldest entry among those flagged ready.
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [DEPTH-1:0] alloc_oh_i,
    input  logic [DEPTH-1:0] free_oh_i,
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] oldest_oh_o
);

    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

    // A new entry becomes younger than every slot; stale rows of free slots
    // never matter because those slots are never ready.
    always_comb begin
        older_d = older_q;
        for (int f = 0; f < DEPTH; f++) begin
            if (free_oh_i[f]) begin
                older_d[f] = '0;
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (alloc_oh_i[a]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    older_d[a][i] = 1'b0;
                    older_d[i][a] = (i != a);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    always_comb begin
        oldest_oh_o = '0;
        for (int j = 0; j < DEPTH; j++) begin
            oldest_oh_o[j] = ready_i[j];
            for (int i = 0; i < DEPTH; i++) begin
                if (i != j && ready_i[i] && older_q[i][j]) begin
                    oldest_oh_o[j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/res_station_bank.sv
// Multi-entry reservation station: holds issued micro-ops, snoops the CDB
// lanes for operands, and dispatches the oldest ready entry to its ALU.
module res_station_bank
    import tomasula_types::op_t;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       load_word,
    output logic                       load_ready,
    input  op_t                        in_op,
    input  logic [2:0]                 in_funct3,
    input  logic                       in_funct7,
    input  logic [TAG_W-1:0]           in_src1_tag,
    input  logic [TAG_W-1:0]           in_src2_tag,
    input  logic [DATA_W-1:0]          in_src1_data,
    input  logic [DATA_W-1:0]          in_src2_data,
    input  logic                       in_src1_valid,
    input  logic                       in_src2_valid,
    input  logic [TAG_W-1:0]           in_rd_tag,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output op_t                        issue_op,
    output logic [2:0]                 issue_funct3,
    output logic                       issue_funct7,
    output logic [DATA_W-1:0]          issue_src1,
    output logic [DATA_W-1:0]          issue_src2,
    output logic [TAG_W-1:0]           issue_rd_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              valid;
    } src_t;

    typedef struct packed {
        logic             busy;
        op_t              op;
        logic [2:0]       funct3;
        logic             funct7;
        logic [TAG_W-1:0] rd_tag;
        src_t             src1;
        src_t             src2;
    } entry_t;

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    entry_t           newEntry;
    entry_t           selEntry;
    logic [DEPTH-1:0] busyVec;
    logic [DEPTH-1:0] readyVec;
    logic [DEPTH-1:0] freeSlotOh;
    logic [DEPTH-1:0] allocOh;
    logic [DEPTH-1:0] freeOh;
    logic [DEPTH-1:0] grantOh;
    logic [CNT_W-1:0] occupancy;
    logic             slotFound;
    logic             loadFire;
    logic             issueFire;

    // Lowest CDB lane carrying a matching tag supplies the operand.
    function automatic src_t snoop(input src_t s,
                                   input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*TAG_W-1:0] t,
                                   input logic [NUM_CDB*DATA_W-1:0] d);
        src_t r;
        r = s;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (!s.valid && v[k] && t[k*TAG_W +: TAG_W] == s.tag) begin
                r.data  = d[k*DATA_W +: DATA_W];
                r.valid = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        busyVec   = '0;
        readyVec  = '0;
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busyVec[i]  = entries_q[i].busy;
            readyVec[i] = entries_q[i].busy && entries_q[i].src1.valid && entries_q[i].src2.valid;
            occupancy   = occupancy + CNT_W'(entries_q[i].busy);
        end
    end

    assign count       = occupancy;
    assign empty       = (occupancy == '0);
    assign full        = (occupancy == CNT_W'(DEPTH));
    assign load_ready  = !full;
    assign issue_valid = |readyVec;
    assign loadFire    = load_word && load_ready;
    assign issueFire   = issue_valid && issue_ready;
    assign allocOh     = loadFire ? freeSlotOh : '0;
    assign freeOh      = issueFire ? grantOh : '0;

    always_comb begin
        freeSlotOh = '0;
        slotFound  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!slotFound && !busyVec[i]) begin
                freeSlotOh[i] = 1'b1;
                slotFound     = 1'b1;
            end
        end
    end

    rs_age_matrix #(
        .DEPTH(DEPTH)
    ) ageMatrix (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .alloc_oh_i (allocOh),
        .free_oh_i  (freeOh),
        .ready_i    (readyVec),
        .oldest_oh_o(grantOh)
    );

    always_comb begin
        selEntry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grantOh[i]) begin
                selEntry = selEntry | entries_q[i];
            end
        end
    end

    assign issue_op     = selEntry.op;
    assign issue_funct3 = selEntry.funct3;
    assign issue_funct7 = selEntry.funct7;
    assign issue_src1   = selEntry.src1.data;
    assign issue_src2   = selEntry.src2.data;
    assign issue_rd_tag = selEntry.rd_tag;

    always_comb begin
        newEntry            = '0;
        newEntry.busy       = 1'b1;
        newEntry.op         = in_op;
        newEntry.funct3     = in_funct3;
        newEntry.funct7     = in_funct7;
        newEntry.rd_tag     = in_rd_tag;
        newEntry.src1.tag   = in_src1_tag;
        newEntry.src1.data  = in_src1_data;
        newEntry.src1.valid = in_src1_valid;
        newEntry.src2.tag   = in_src2_tag;
        newEntry.src2.data  = in_src2_data;
        newEntry.src2.valid = in_src2_valid;
        newEntry.src1       = snoop(newEntry.src1, cdb_valid, cdb_tag, cdb_data);
        newEntry.src2       = snoop(newEntry.src2, cdb_valid, cdb_tag, cdb_data);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].busy) begin
                entries_d[i].src1 = snoop(entries_q[i].src1, cdb_valid, cdb_tag, cdb_data);
                entries_d[i].src2 = snoop(entries_q[i].src2, cdb_valid, cdb_tag, cdb_data);
            end
            if (freeOh[i]) begin
                entries_d[i].busy = 1'b0;
            end
            if (allocOh[i]) begin
                entries_d[i] = newEntry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: doc/res_station_bank.md
# res_station_bank

Parametrised multi-entry reservation station for the Tomasulo back end, replacing the single-entry `reservation_station` in front of each ALU. It accepts issued micro-ops from the instruction queue and holds up to `DEPTH` of them. It snoops `NUM_CDB` common-data-bus lanes to capture operands and dispatches the oldest ready entry to its ALU over a valid/ready handshake. A flush input drops all entries on mispredict or exception recovery.

## Interface
- `DEPTH`, 4: number of entries, ≥2.
- `TAG_W`, 3: ROB tag width; tags 0..2^TAG_W-1.
- `DATA_W`, 32: operand/result width.
- `NUM_CDB`, 2: number of CDB broadcast lanes, ≥1.

- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries; same effect as `rst`.
- `load_word` in 1: enqueue request.
- `load_ready` out 1: `!full`; enqueue accepted iff `load_word && load_ready`.
- `in_op` in `tomasula_types::op_t`: operation class.
- `in_funct3` in 3: funct3.
- `in_funct7` in 1: funct7 bit.
- `in_src1_tag`, `in_src2_tag` in `TAG_W`: producer ROB tags.
- `in_src1_data`, `in_src2_data` in `DATA_W`: operand values, meaningful when the matching valid bit is set.
- `in_src1_valid`, `in_src2_valid` in 1: operand already available.
- `in_rd_tag` in `TAG_W`: destination ROB tag.
- `cdb_valid` in `NUM_CDB`: per-lane broadcast strobe.
- `cdb_tag` in `NUM_CDB*TAG_W`: per-lane tag; lane k occupies bits [k*TAG_W +: TAG_W].
- `cdb_data` in `NUM_CDB*DATA_W`: per-lane result, packed the same way.
- `issue_valid` out 1: a ready entry is presented.
- `issue_ready` in 1: ALU accepts.
- `issue_op`, `issue_funct3`, `issue_funct7`, `issue_src1`, `issue_src2`, `issue_rd_tag` out: fields of the selected entry.
- `count` out `$clog2(DEPTH+1)`: occupied entries.
- `empty`, `full` out 1: `count==0` and `count==DEPTH`.

## Operation
- Entry state: `busy`, payload, and per-source {`tag`, `data`, `valid`}.
- Allocation: on an accepted load, write the lowest-index non-busy entry and mark it youngest.
- Load bypass: an incoming invalid source whose tag matches any valid CDB lane in the same cycle is stored with `valid=1` and that lane's data.
- Wakeup: each cycle, every busy entry with an invalid source compares its tag against all valid lanes. On a match it captures the data and sets `valid`. If several lanes match, the lowest lane index wins.
- Ready: `busy && src1.valid && src2.valid`, evaluated from registered state.
- Select: the oldest ready entry, chosen by the age matrix, drives `issue_*`. `issue_valid` = any ready entry. The selection is combinational from state.
- Dispatch: on `issue_valid && issue_ready`, clear the selected entry's `busy` at the edge.
- Load and dispatch may happen in the same cycle. The count changes by +1, 0 or −1 accordingly.
- `issue_*` payload outputs are don't-care when `issue_valid=0`; the bench checks them only when valid.
- Flush or rst: all `busy` bits cleared, so `count=0`, `empty=1`, `full=0`, `load_ready=1`, `issue_valid=0`. This applies even mid-operation; a load or dispatch in a flush cycle is discarded.

## Timing
- Load at edge N: the entry is visible from cycle N+1. If both operands were valid or bypassed, `issue_valid=1` in cycle N+1.
- CDB broadcast in cycle N: the captured operand makes the entry ready in cycle N+1, i.e. 1-cycle wakeup-to-issue. There is no same-cycle CDB-to-issue forwarding.
- `load_ready` depends on registered `count` only, not on `issue_ready`. When full, a same-cycle dispatch does not admit a load; the freed slot is usable from the next cycle.
- `issue_valid` must not depend on `issue_ready`.
- If `issue_ready=0`, the selected entry stays until accepted. It can be displaced only by an older entry becoming ready.

## Structure
- `tomasula_types` holds `op_t`. It gains an `rs_entry_t` struct template and a `cdb_lane_t` struct; widths follow the package `TAG_W`/`DATA_W` localparams.
- The age tracker is a sub-module, `rs_age_matrix`, parameter `DEPTH`. It is a DEPTH×DEPTH older-than bit matrix with inputs for alloc one-hot, free one-hot and ready vector, and a one-hot oldest-ready output.
- Top level: entry array, CDB compare logic, allocation priority encoder, one-hot output mux.

## Test plan
- Reset: after `rst` for 1 cycle, `count=0`, `empty=1`, `load_ready=1`, `issue_valid=0`.
- Ready-at-load: load `in_src1_data=5` and `in_src2_data=3`, both valid, `in_rd_tag=2`, `issue_ready=1`. The next cycle gives `issue_valid=1`, `issue_src1=5`, `issue_src2=3`, `issue_rd_tag=2`; the cycle after, `empty=1`.
- Wakeup: load with src1 tag 1 invalid, then pulse CDB lane 1 with tag 1, data `0xAB`. `issue_valid` rises exactly one cycle after the pulse, with `issue_src1=0xAB`.
- Bypass: load src2 tag 4 invalid while lane 0 broadcasts tag 4, data `0x77`. The next cycle gives `issue_valid=1`, `issue_src2=0x77`.
- Oldest-first and backpressure: fill 4 entries (rd_tags 0,1,2,3), all ready, with `issue_ready=0`. Check `full=1`, `load_ready=0`, and issue_rd_tag held at 0. Then assert `issue_ready` and check dispatch order 0,1,2,3, one per cycle.
- Flush mid-operation: with 3 entries busy and a load asserted, pulse `flush`. The next cycle gives `count=0` and `issue_valid=0`; the load was dropped.
